// File: rtl/awb_pkg.sv
// awb_pkg: shared constants and types for the auto-white-balance gain stage.
//   FRAC_BITS_DEF : default number of fractional gain bits
//   UNITY_GAIN    : gain of 1.0 at the default fraction width
//   color_e       : pixel color codes (3 is reserved and passes through)
//   state_e       : gain-computation FSM states
package awb_pkg;
    localparam int FRAC_BITS_DEF = 6;
    localparam logic [7:0] UNITY_GAIN = 8'(1 << FRAC_BITS_DEF);
    typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2} color_e;
    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, PEND} state_e;
endpackage

// File: rtl/awb_gain_if.sv
// awb_gain_if: one-pixel-per-cycle stream without backpressure.
//   valid : pixel qualifier
//   color : 0=R, 1=G, 2=B, 3=reserved
//   value : 8-bit pixel value
//   last  : last pixel of the frame, qualified by valid
//   master drives the stream, slave receives it
interface awb_gain_if;
    logic       valid;
    logic [1:0] color;
    logic [7:0] value;
    logic       last;
    modport master (output valid, color, value, last);
    modport slave  (input valid, color, value, last);
endinterface

// File: rtl/awb_divider.sv
// awb_divider: serial restoring divider, (dividend << FRAC_BITS) / divisor.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load operands and perform the first quotient step this cycle
//   abort_i    : drop any division in progress
//   dividend_i : 8-bit dividend, shifted left by FRAC_BITS internally
//   divisor_i  : 8-bit non-zero divisor, sampled on start_i
//   busy_o     : a division is in progress from a previous start
//   done_o     : the final quotient step happens this cycle; quot_o is valid
//   quot_o     : quotient saturated to 255
module awb_divider
    import awb_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] dividend_i,
    input  logic [7:0] divisor_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] quot_o
);
    localparam int QW = 8 + FRAC_BITS;
    localparam int CW = $clog2(QW);

    logic          busy_q, busy_d, active;
    logic [7:0]    rem_q, rem_d, rem_c;
    logic [7:0]    dsr_q, dsr_d;
    logic [QW-1:0] quo_q, quo_d, quo_c;
    logic [CW-1:0] cnt_q, cnt_d, cnt_c;
    logic [8:0]    trial;
    logic          fit;

    // A start performs its first step in the same cycle, so QW steps span exactly QW cycles.
    always_comb begin
        rem_c  = start_i ? 8'd0 : rem_q;
        quo_c  = start_i ? {dividend_i, {FRAC_BITS{1'b0}}} : quo_q;
        cnt_c  = start_i ? '0 : cnt_q;
        dsr_d  = start_i ? divisor_i : dsr_q;
        active = start_i || busy_q;
        trial  = {rem_c, quo_c[QW-1]};
        fit    = trial >= {1'b0, dsr_d};
        rem_d  = fit ? 8'(trial - {1'b0, dsr_d}) : trial[7:0];
        quo_d  = {quo_c[QW-2:0], fit};
        cnt_d  = cnt_c + CW'(1);
        done_o = !abort_i && active && (cnt_c == CW'(QW - 1));
        busy_d = !abort_i && active && (cnt_c != CW'(QW - 1));
        quot_o = |quo_d[QW-1:8] ? 8'hFF : quo_d[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            dsr_q  <= dsr_d;
        end
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/awb_gain.sv
// awb_gain: gray-world white balance; derives R/B gains from frame means and applies them.
//   clk, rst        : clock, synchronous active-high reset
//   mean_valid_i    : one-cycle pulse, r/g/b_mean_i valid
//   r/g/b_mean_i    : frame channel means
//   pix_i           : input pixel stream (slave)
//   pix_o           : gain-corrected pixel stream, 2-cycle latency (master)
//   gain_r_o/b_o    : active gains, unity = 1 << FRAC_BITS
//   busy_o          : division running or gains pending
// Build option: define AWB_GAIN_LIMIT_EN to clamp computed gains to 0.5..2.0.
module awb_gain
    import awb_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mean_valid_i,
    input  logic [7:0]       r_mean_i,
    input  logic [7:0]       g_mean_i,
    input  logic [7:0]       b_mean_i,
    awb_gain_if.slave        pix_i,
    awb_gain_if.master       pix_o,
    output logic [7:0]       gain_r_o,
    output logic [7:0]       gain_b_o,
    output logic             busy_o
);
    localparam logic [7:0] UNITY = 8'(1 << FRAC_BITS);
`ifdef AWB_GAIN_LIMIT_EN
    localparam logic [7:0] GAIN_LO = 8'(1 << (FRAC_BITS - 1));
    localparam logic [7:0] GAIN_HI = 8'(1 << (FRAC_BITS + 1));
`endif

    function automatic logic [7:0] limit(input logic [7:0] g);
`ifdef AWB_GAIN_LIMIT_EN
        return (g < GAIN_LO) ? GAIN_LO : (g > GAIN_HI) ? GAIN_HI : g;
`else
        return g;
`endif
    endfunction

    state_e     state_q, state_d;
    logic [7:0] r_mean_q, r_mean_d, g_mean_q, g_mean_d, b_mean_q, b_mean_d;
    logic [7:0] gain_r_pend_q, gain_r_pend_d, gain_b_pend_q, gain_b_pend_d;
    logic [7:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
    logic       in_frame_q, in_frame_d;
    logic       div_start, div_busy, div_done;
    logic [7:0] div_divisor, div_quot, div_result;

    logic       s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [1:0] s1_color_q, s1_color_d;
    logic [7:0] s1_value_q, s1_value_d, s1_gain_q, s1_gain_d;
    logic       out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [1:0] out_color_q, out_color_d;
    logic [7:0] out_value_q, out_value_d;
    logic [15:0] product, scaled;

    awb_divider #(.FRAC_BITS(FRAC_BITS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start),
        .abort_i   (mean_valid_i),
        .dividend_i(g_mean_q),
        .divisor_i (div_divisor),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quot_o    (div_quot)
    );

    // A new mean pulse always wins: recapture and restart, dropping any pending gains.
    always_comb begin
        state_d       = state_q;
        r_mean_d      = r_mean_q;
        g_mean_d      = g_mean_q;
        b_mean_d      = b_mean_q;
        gain_r_pend_d = gain_r_pend_q;
        gain_b_pend_d = gain_b_pend_q;
        gain_r_d      = gain_r_q;
        gain_b_d      = gain_b_q;
        in_frame_d    = pix_i.valid ? !pix_i.last : in_frame_q;
        div_divisor   = (state_q == DIV_B) ? b_mean_q : r_mean_q;
        div_result    = (div_divisor == 8'd0) ? UNITY : div_quot;
        div_start     = 1'b0;
        if (mean_valid_i) begin
            r_mean_d = r_mean_i;
            g_mean_d = g_mean_i;
            b_mean_d = b_mean_i;
            state_d  = DIV_R;
        end else begin
            case (state_q)
                DIV_R: begin
                    div_start = (div_divisor != 8'd0) && !div_busy;
                    if (div_divisor == 8'd0 || div_done) begin
                        gain_r_pend_d = limit(div_result);
                        state_d       = DIV_B;
                    end
                end
                DIV_B: begin
                    div_start = (div_divisor != 8'd0) && !div_busy;
                    if (div_divisor == 8'd0 || div_done) begin
                        gain_b_pend_d = limit(div_result);
                        state_d       = PEND;
                    end
                end
                PEND: begin
                    // Commit only between frames so no frame sees mixed gains.
                    if (!in_frame_q && !pix_i.valid) begin
                        gain_r_d = gain_r_pend_q;
                        gain_b_d = gain_b_pend_q;
                        state_d  = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 1 latches the gain in force at entry; G and reserved use unity, which passes exactly.
    always_comb begin
        s1_valid_d  = pix_i.valid;
        s1_color_d  = pix_i.color;
        s1_value_d  = pix_i.value;
        s1_last_d   = pix_i.last;
        s1_gain_d   = (pix_i.color == RED) ? gain_r_q : (pix_i.color == BLUE) ? gain_b_q : UNITY;
        product     = 16'(s1_value_q) * 16'(s1_gain_q);
        scaled      = product >> FRAC_BITS;
        out_valid_d = s1_valid_q;
        out_color_d = s1_color_q;
        out_last_d  = s1_last_q;
        out_value_d = |scaled[15:8] ? 8'hFF : scaled[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            r_mean_q      <= '0;
            g_mean_q      <= '0;
            b_mean_q      <= '0;
            gain_r_pend_q <= UNITY;
            gain_b_pend_q <= UNITY;
            gain_r_q      <= UNITY;
            gain_b_q      <= UNITY;
            in_frame_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_color_q    <= '0;
            s1_value_q    <= '0;
            s1_last_q     <= 1'b0;
            s1_gain_q     <= '0;
            out_valid_q   <= 1'b0;
            out_color_q   <= '0;
            out_value_q   <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_mean_q      <= r_mean_d;
            g_mean_q      <= g_mean_d;
            b_mean_q      <= b_mean_d;
            gain_r_pend_q <= gain_r_pend_d;
            gain_b_pend_q <= gain_b_pend_d;
            gain_r_q      <= gain_r_d;
            gain_b_q      <= gain_b_d;
            in_frame_q    <= in_frame_d;
            s1_valid_q    <= s1_valid_d;
            s1_color_q    <= s1_color_d;
            s1_value_q    <= s1_value_d;
            s1_last_q     <= s1_last_d;
            s1_gain_q     <= s1_gain_d;
            out_valid_q   <= out_valid_d;
            out_color_q   <= out_color_d;
            out_value_q   <= out_value_d;
            out_last_q    <= out_last_d;
        end
    end

    assign pix_o.valid = out_valid_q;
    assign pix_o.color = out_color_q;
    assign pix_o.value = out_value_q;
    assign pix_o.last  = out_last_q;
    assign gain_r_o    = gain_r_q;
    assign gain_b_o    = gain_b_q;
    assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_awb_gain.sv
// tb_awb_gain: randomized and directed bench for awb_gain against a behavioural model.
module tb_awb_gain;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mean_valid = 1'b0;
    logic [7:0] r_mean = '0, g_mean = '0, b_mean = '0;
    logic [7:0] gain_r, gain_b;
    logic       busy;

    awb_gain_if pin ();
    awb_gain_if pout ();

    awb_gain dut (
        .clk         (clk),
        .rst         (rst),
        .mean_valid_i(mean_valid),
        .r_mean_i    (r_mean),
        .g_mean_i    (g_mean),
        .b_mean_i    (b_mean),
        .pix_i       (pin),
        .pix_o       (pout),
        .gain_r_o    (gain_r),
        .gain_b_o    (gain_b),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] c;
        logic [7:0] v;
        logic       l;
    } pix_t;

    pix_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    bit   mon_en = 0;

    int   cyc = 0;
    int   m_gr = 64, m_gb = 64, p_gr = 64, p_gb = 64;
    bit   m_pend = 0, m_in_frame = 0;
    int   pend_at = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) $display("FAIL %s: got %0d expected %0d", nm, act, want);
        else n_pass++;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Gray-world gain: G mean over channel mean in Q2.6, unity when the channel mean is 0.
    function automatic int gain_of(input int g, input int d);
        int q;
        q = (d == 0) ? 64 : sat((g * 64) / d);
`ifdef AWB_GAIN_LIMIT_EN
        q = (q < 32) ? 32 : (q > 128) ? 128 : q;
`endif
        return q;
    endfunction

    function automatic int div_len(input int d);
        return (d == 0) ? 1 : 14;
    endfunction

    task automatic tick(input bit v, input bit [1:0] c, input bit [7:0] x, input bit l,
                        input bit mv, input bit [7:0] r, input bit [7:0] g, input bit [7:0] b,
                        input bit rs);
        pix_t e;
        @(negedge clk);
        rst        = rs;
        pin.valid  = v;
        pin.color  = c;
        pin.value  = x;
        pin.last   = l;
        mean_valid = mv;
        r_mean     = r;
        g_mean     = g;
        b_mean     = b;
        if (rs) begin
            m_gr = 64; m_gb = 64; m_pend = 0; m_in_frame = 0;
            exp_q.delete();
        end else begin
            if (v) begin
                e.c = c;
                e.l = l;
                e.v = 8'((c == 2'd0) ? sat(x * m_gr / 64) : (c == 2'd2) ? sat(x * m_gb / 64) : x);
                exp_q.push_back(e);
            end
            if (mv) begin
                m_pend  = 1;
                pend_at = cyc + div_len(r) + div_len(b) + 1;
                p_gr    = gain_of(g, r);
                p_gb    = gain_of(g, b);
            end else if (m_pend && cyc >= pend_at && !m_in_frame && !v) begin
                m_gr   = p_gr;
                m_gb   = p_gb;
                m_pend = 0;
            end
            if (v) m_in_frame = !l;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input bit [1:0] c, input bit [7:0] x, input bit l);
        tick(1, c, x, l, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse(input bit [7:0] r, input bit [7:0] g, input bit [7:0] b);
        tick(0, 0, 0, 0, 1, r, g, b, 0);
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++)
            pix(2'($urandom_range(0, 3)), 8'($urandom), i == n - 1);
    endtask

    always @(posedge clk) begin
        pix_t e;
        #1;
        if (mon_en) begin
            chk("gain_r", gain_r, m_gr);
            chk("gain_b", gain_b, m_gb);
            chk("busy", busy, m_pend);
            if (pout.valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pixel: got valid_o=1 expected no pixel");
                end else begin
                    e = exp_q.pop_front();
                    chk("color_o", pout.color, e.c);
                    chk("value_o", pout.value, e.v);
                    chk("last_o", pout.last, e.l);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        pin.valid = 0; pin.color = 0; pin.value = 0; pin.last = 0;
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
        mon_en = 1;
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        chk("reset_valid", pout.valid, 0);
        chk("reset_value", pout.value, 0);
        chk("reset_gain_r", gain_r, 8'h40);
        chk("reset_gain_b", gain_b, 8'h40);

        pix(0, 100, 0); pix(1, 50, 0); pix(2, 200, 1);
        idle(3);

        pulse(64, 128, 128);
        idle(35);
        chk("gain_r_x2", gain_r, 8'h80);
        chk("gain_b_x1", gain_b, 8'h40);
        pix(0, 100, 0); pix(0, 200, 1);
        idle(3);

        pulse(0, 200, 25);
        idle(20);
        chk("gain_r_zero_div", gain_r, 8'h40);
`ifdef AWB_GAIN_LIMIT_EN
        chk("gain_b_limit", gain_b, 8'h80);
`else
        chk("gain_b_sat", gain_b, 8'hFF);
`endif
        pix(2, 10, 0); pix(2, 200, 1);
        idle(3);

        pulse(128, 64, 32);
        frame(40);
        chk("gain_r_held_in_frame", gain_r, 8'h40);
        idle(1);
        idle(1);
        chk("gain_r_after_frame", gain_r, 8'h20);
        idle(3);

        pulse(10, 200, 10);
        idle(9);
        pulse(100, 100, 50);
        idle(35);
        chk("gain_r_restart", gain_r, 8'h40);
        chk("gain_b_restart", gain_b, 8'h80);

        pulse(50, 100, 25);
        for (int i = 0; i < 19; i++) pix(2'($urandom_range(0, 3)), 8'($urandom), 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        chk("rst_mid_valid", pout.valid, 0);
        chk("rst_mid_value", pout.value, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_gain_r", gain_r, 8'h40);
        chk("rst_mid_gain_b", gain_b, 8'h40);

        for (int i = 0; i < 1500; i++) begin
            bit v, mv, l;
            bit [7:0] r, b;
            v  = $urandom_range(0, 3) != 0;
            mv = $urandom_range(0, 79) == 0;
            l  = v && ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 499) == 0) tick(0, 0, 0, 0, 0, 0, 0, 0, 1);
            else tick(v, 2'($urandom_range(0, 3)), 8'($urandom), l, mv, r,
                      8'($urandom_range(0, 255)), b, 0);
        end
        pix(1, 1, 1);
        idle(40);
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
